cacheline_adapter: RTL and testbench

Converts single-transfer 256-bit cache-line requests from the cache controller into 4-beat 64-bit bursts on the main-memory port, and reassembles read bursts into a full line. It sits directly downstream of the cache controller and datapath: it consumes `ram_read_i`/`ram_write_i`/address/line, and returns `ram_resp_o`/`ram_line_o`. One request is serviced at a time.

---
 rtl/cacheline_adapter.sv | 127 ++++++++++++
 tb/tb_cacheline_adapter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adapter.sv
// cacheline_adapter: splits 256-bit line requests into 64-bit memory
// bursts and reassembles read bursts into a full cache line.
module cacheline_adapter #(
    parameter int s_line  = 256,
    parameter int s_burst = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [s_line-1:0]  line_i,
    output logic [s_line-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [s_burst-1:0] burst_i,
    output logic [s_burst-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    localparam int burst_len = s_line / s_burst;
    localparam int s_offset  = $clog2(s_line / 8);
    localparam int CW        = $clog2(burst_len);

    localparam logic [31:0]   OFF_MASK = (32'd1 << s_offset) - 32'd1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(burst_len - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t                            state_q, state_d;
    logic [CW-1:0]                     cnt_q, cnt_d;
    logic [burst_len-1:0][s_burst-1:0] buf_q, buf_d;
    logic [31:0]                       addr_q, addr_d;
    logic [31:0]                       line_addr;
    logic                              cnt_last;

    assign line_addr = address_i & ~OFF_MASK;
    assign cnt_last  = (cnt_q == CNT_LAST);

    // State, beat counter, line buffer and address registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state: accept a request in IDLE, count acknowledged beats
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE: begin
                if (write_i) begin
                    addr_d  = line_addr;
                    buf_d   = line_i;
                    cnt_d   = '0;
                    state_d = WRITE;
                end else if (read_i) begin
                    addr_d  = line_addr;
                    cnt_d   = '0;
                    state_d = READ;
                end
            end
            READ: begin
                if (resp_i) begin
                    buf_d[cnt_q] = burst_i;
                    cnt_d        = cnt_q + CNT_ONE;
                    if (cnt_last) state_d = DONE;
                end
            end
            WRITE: begin
                if (resp_i) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_last) state_d = DONE;
                end
            end
            DONE: begin
                // Held request lines are ignored here so they cannot re-trigger
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs decoded from state and registers only
    always_comb begin
        read_o    = 1'b0;
        write_o   = 1'b0;
        resp_o    = 1'b0;
        address_o = '0;
        burst_o   = '0;
        unique case (state_q)
            READ: begin
                read_o    = 1'b1;
                address_o = addr_q;
            end
            WRITE: begin
                write_o   = 1'b1;
                address_o = addr_q;
                burst_o   = buf_q[cnt_q];
            end
            DONE:    resp_o = 1'b1;
            default: ;
        endcase
    end

    assign line_o = buf_q;

endmodule

// File: tb/tb_cacheline_adapter.sv
// tb_cacheline_adapter: directed table, corner sequences and randomized
// transactions checked against a line/beat-level memory model.
module tb_cacheline_adapter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [255:0] line_i = '0;
    logic [255:0] line_o;
    logic [31:0]  address_i = '0;
    logic         read_i = 1'b0;
    logic         write_i = 1'b0;
    logic         resp_o;
    logic [63:0]  burst_i = '0;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i = 1'b0;

    int checks = 0;
    int errors = 0;

    cacheline_adapter dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         wr;
        logic         both;
        logic [31:0]  addr;
        logic [255:0] line;
        logic [3:0][3:0] w;
        logic [31:0]  exp_addr;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_ctl"}, {read_o, write_o, resp_o}, 3'b000);
        chk({nm, "_addr"}, address_o, 32'h0);
        chk({nm, "_burst"}, burst_o, 64'h0);
    endtask

    // One full line transaction seen from the cache and the memory side.
    // Memory acknowledges beat k after w[k] idle cycles.
    task automatic run_txn(input logic wr_in, input logic both,
                           input logic [31:0] addr, input logic [255:0] line,
                           input logic [3:0][3:0] w,
                           input logic [31:0] exp_addr);
        int  k;
        int  g;
        int  n;
        int  waits;
        bit  done;
        logic wr;
        wr    = wr_in | both;
        k     = 0;
        g     = 0;
        n     = 0;
        waits = 0;
        done  = 0;
        for (int i = 0; i < 4; i++) waits += int'(w[i]);
        write_i   = wr;
        read_i    = !wr_in | both;
        address_i = addr;
        line_i    = wr ? line : {8{$urandom}};
        resp_i    = 1'b0;
        while (!done && n < 200) begin
            tick();
            n++;
            if (resp_o) begin
                done = 1;
                chk("resp_latency", n, 5 + waits);
                chk("done_ctl", {read_o, write_o}, 2'b00);
                if (!wr) chk("line_o", line_o, line);
            end else begin
                chk(wr ? "write_o" : "read_o", {read_o, write_o},
                    wr ? 2'b01 : 2'b10);
                chk("address_o", address_o, exp_addr);
                if (wr) chk("burst_o", burst_o, line[k*64 +: 64]);
                if (k >= 4 || g < int'(w[k])) begin
                    resp_i = 1'b0;
                    g++;
                end else begin
                    resp_i  = 1'b1;
                    burst_i = wr ? {$urandom, $urandom} : line[k*64 +: 64];
                    g = 0;
                    k++;
                end
            end
        end
        if (!done) chk("resp_timeout", 1'b0, 1'b1);
        // Request still held through DONE; stray resp_i must be ignored
        resp_i  = $urandom_range(0, 1);
        burst_i = {$urandom, $urandom};
        tick();
        chk("resp_pulse", resp_o, 1'b0);
        chk("no_retrigger", {read_o, write_o}, 2'b00);
        if (!wr) chk("line_hold", line_o, line);
        read_i  = 1'b0;
        write_i = 1'b0;
        resp_i  = 1'b0;
    endtask

    initial begin
        logic [255:0] rl;
        logic [255:0] held;
        logic [3:0][3:0] rw;
        logic [31:0]  ra;
        logic         rwr;
        logic         rboth;

        tbl[0] = '{1'b0, 1'b0, 32'h0000_1234,
                   {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                   16'h0000, 32'h0000_1220};
        tbl[1] = '{1'b1, 1'b0, 32'h0000_4000,
                   {64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0002,
                    64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0000},
                   16'h2222, 32'h0000_4000};
        tbl[2] = '{1'b1, 1'b1, 32'hFFFF_FFFF,
                   {64'hA5A5_0000_0000_0004, 64'h5A5A_0000_0000_0003,
                    64'hC3C3_0000_0000_0002, 64'h3C3C_0000_0000_0001},
                   16'h0100, 32'hFFFF_FFE0};
        tbl[3] = '{1'b0, 1'b0, 32'h0000_001F,
                   {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                    64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF},
                   16'h1030, 32'h0000_0000};
        tbl[4] = '{1'b1, 1'b0, 32'h8000_0020,
                   {64'h1, 64'h2, 64'h3, 64'h4},
                   16'h0001, 32'h8000_0020};
        tbl[5] = '{1'b0, 1'b0, 32'h7654_3210,
                   {64'hAAAA_BBBB_CCCC_DDDD, 64'h1234_5678_9ABC_DEF0,
                    64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0},
                   16'h0000, 32'h7654_3200};

        // Reset state
        tick();
        chk_idle("reset");
        chk("reset_line", line_o, 256'h0);
        rst = 1'b1;
        tick();
        chk_idle("post_reset");

        // Directed table; consecutive entries also cover write-then-fetch
        for (int i = 0; i < 6; i++)
            run_txn(tbl[i].wr, tbl[i].both, tbl[i].addr, tbl[i].line,
                    tbl[i].w, tbl[i].exp_addr);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle("after_chain");
        end

        // Stray resp_i in IDLE leaves buffer and outputs untouched
        held = tbl[5].line;
        for (int i = 0; i < 3; i++) begin
            resp_i  = 1'b1;
            burst_i = {$urandom, $urandom};
            tick();
            chk_idle("stray");
            chk("stray_line", line_o, held);
        end
        resp_i = 1'b0;

        // Async reset after two read beats
        read_i    = 1'b1;
        address_i = 32'h0000_2040;
        tick();
        chk("rst_mid_read", read_o, 1'b1);
        resp_i  = 1'b1;
        burst_i = 64'h9999_9999_9999_9999;
        tick();
        burst_i = 64'h8888_8888_8888_8888;
        tick();
        resp_i = 1'b0;
        rst = 1'b0;
        #1;
        chk_idle("async_rst");
        chk("async_rst_line", line_o, 256'h0);
        read_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_idle("rst_release");
            chk("rst_release_line", line_o, 256'h0);
        end

        // Randomized transactions against the line/beat model
        for (int t = 0; t < 40; t++) begin
            rl    = {$urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom};
            ra    = $urandom;
            rwr   = $urandom_range(0, 1);
            rboth = ($urandom_range(0, 5) == 0);
            for (int b = 0; b < 4; b++)
                rw[b] = ($urandom_range(0, 2) == 0) ?
                        4'($urandom_range(1, 3)) : 4'd0;
            run_txn(rwr, rboth, ra, rl, rw, ra & ~32'h1F);
            for (int d = $urandom_range(0, 2); d > 0; d--) begin
                tick();
                chk_idle("rand_gap");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
